// File: rtl/riscv_wb_ctrl_if.sv
// Decode / operand / regfile-write bundle for riscv_wb_ctrl.
// master drives decode fields and stage data; slave is the controller.
interface riscv_wb_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) ();
  logic              dec_valid_i;
  logic [REG_AW-1:0] dec_rd_i;
  logic              dec_we_i;
  logic              dec_load_i;
  logic              dec_ready_o;
  logic [REG_AW-1:0] AddrA_i;
  logic [REG_AW-1:0] AddrB_i;
  logic              renA_i;
  logic              renB_i;
  logic              flush_i;
  logic [XLEN-1:0]   ex_result_i;
  logic [XLEN-1:0]   mem_rdata_i;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic [XLEN-1:0]   fwd_data_a_o;
  logic [XLEN-1:0]   fwd_data_b_o;
  logic              stall_o;
  logic              RegWEn_o;
  logic [REG_AW-1:0] AddrD_o;
  logic [XLEN-1:0]   DataD_o;

  modport master (
    output dec_valid_i, dec_rd_i, dec_we_i, dec_load_i, AddrA_i, AddrB_i,
           renA_i, renB_i, flush_i, ex_result_i, mem_rdata_i,
    input  dec_ready_o, fwd_a_o, fwd_b_o, fwd_data_a_o, fwd_data_b_o,
           stall_o, RegWEn_o, AddrD_o, DataD_o
  );

  modport slave (
    input  dec_valid_i, dec_rd_i, dec_we_i, dec_load_i, AddrA_i, AddrB_i,
           renA_i, renB_i, flush_i, ex_result_i, mem_rdata_i,
    output dec_ready_o, fwd_a_o, fwd_b_o, fwd_data_a_o, fwd_data_b_o,
           stall_o, RegWEn_o, AddrD_o, DataD_o
  );
endinterface

// File: rtl/riscv_wb_ctrl.sv
// riscv_wb_ctrl: carries rd/result through EX, MEM, WB, drives the regfile
// write port from WB, and resolves decode RAW hazards (forwarding + stalls).
// Optional macro WB_BYPASS_EN: forward from WB (select 3); without it a
// WB-only match stalls one cycle so decode rereads the written regfile.
module riscv_wb_ctrl #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic            clk_i,
  input logic            rst_i,
  riscv_wb_ctrl_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } tag_t;

  typedef struct packed {
    logic [1:0]      sel;
    logic [XLEN-1:0] data;
    logic            stl;
  } fwd_t;

  tag_t              ex_q, mem_q;
  logic [XLEN-1:0]   mem_data;
  logic              wb_valid, wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  fwd_t              fa, fb;
  logic              stall;

  function automatic logic hit(input logic v, input logic we,
                               input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] addr,
                               input logic ren);
    return v & we & (rd == addr) & (addr != '0) & ren;
  endfunction

  // Youngest matching stage wins; a load still in EX cannot be forwarded yet.
  function automatic fwd_t resolve(input logic [REG_AW-1:0] addr,
                                   input logic ren);
    fwd_t r;
    r = '0;
    if (hit(ex_q.valid, ex_q.we, ex_q.rd, addr, ren)) begin
      r.sel  = 2'd1;
      r.data = bus.ex_result_i;
      r.stl  = ex_q.load;
    end else if (hit(mem_q.valid, mem_q.we, mem_q.rd, addr, ren)) begin
      r.sel  = 2'd2;
      r.data = mem_q.load ? bus.mem_rdata_i : mem_data;
    end else if (hit(wb_valid, wb_we, wb_rd, addr, ren)) begin
`ifdef WB_BYPASS_EN
      r.sel  = 2'd3;
      r.data = wb_data;
`else
      r.stl  = 1'b1;
`endif
    end
    return r;
  endfunction

  // Per-source forwarding selection and hazard detection.
  always_comb begin
    fa = resolve(bus.AddrA_i, bus.renA_i);
    fb = resolve(bus.AddrB_i, bus.renB_i);
  end

  assign stall            = fa.stl | fb.stl;
  assign bus.stall_o      = stall;
  assign bus.fwd_a_o      = fa.sel;
  assign bus.fwd_b_o      = fb.sel;
  assign bus.fwd_data_a_o = fa.data;
  assign bus.fwd_data_b_o = fb.data;
  assign bus.dec_ready_o  = bus.dec_valid_i & ~stall & ~bus.flush_i;

  // Write port comes straight from WB flops, so address and data stay aligned.
  assign bus.RegWEn_o = wb_valid & wb_we & (wb_rd != '0);
  assign bus.AddrD_o  = wb_rd;
  assign bus.DataD_o  = wb_data;

  // Stage advance: EX takes decode or a bubble; MEM and WB never stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q     <= '0;
      mem_q    <= '0;
      mem_data <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      if (bus.flush_i | stall) ex_q <= '0;
      else ex_q <= tag_t'{bus.dec_valid_i, bus.dec_rd_i, bus.dec_we_i, bus.dec_load_i};
      mem_q    <= ex_q;
      mem_data <= bus.ex_result_i;
      wb_valid <= mem_q.valid;
      wb_we    <= mem_q.we;
      wb_rd    <= mem_q.rd;
      wb_data  <= mem_q.load ? bus.mem_rdata_i : mem_data;
    end
  end

endmodule

// File: tb/tb_riscv_wb_ctrl.sv
// Self-checking bench for riscv_wb_ctrl: directed scenarios plus random
// traffic against a model that tracks each accepted instruction by age.
module tb_riscv_wb_ctrl;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk, rst;
  int   checks, errors;

  riscv_wb_ctrl_if #(.XLEN(32), .REG_AW(5)) bus ();
  riscv_wb_ctrl #(.XLEN(32), .REG_AW(5)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Model: every accepted instruction with its age (1=EX, 2=MEM, 3=WB).
  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [31:0] data;
    int          age;
  } ins_t;
  ins_t q[$];
  logic exp_accept;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int youngest(input logic [4:0] a, input logic r);
    int best = -1;
    if (!r || a == 5'd0) return -1;
    foreach (q[i])
      if (q[i].we && q[i].rd == a && (best < 0 || q[i].age < q[best].age)) best = i;
    return best;
  endfunction

  function automatic logic [31:0] fdata(input int i);
    if (q[i].age == 1) return bus.ex_result_i;
    if (q[i].age == 2 && q[i].ld) return bus.mem_rdata_i;
    return q[i].data;
  endfunction

  task automatic set_dec(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                         input logic [4:0] a, input logic ra, input logic [4:0] b,
                         input logic rb, input logic fl);
    bus.dec_valid_i = v;  bus.dec_rd_i = rd; bus.dec_we_i = we; bus.dec_load_i = ld;
    bus.AddrA_i = a; bus.renA_i = ra; bus.AddrB_i = b; bus.renB_i = rb; bus.flush_i = fl;
  endtask

  // Compare all outputs against the model mid-cycle.
  task automatic settle();
    int  ia, ib, w;
    logic st;
    #3;
    ia = youngest(bus.AddrA_i, bus.renA_i);
    ib = youngest(bus.AddrB_i, bus.renB_i);
    st = 1'b0;
    if (ia >= 0 && ((q[ia].age == 1 && q[ia].ld) || (q[ia].age == 3 && !BYPASS))) st = 1'b1;
    if (ib >= 0 && ((q[ib].age == 1 && q[ib].ld) || (q[ib].age == 3 && !BYPASS))) st = 1'b1;
    exp_accept = bus.dec_valid_i & ~st & ~bus.flush_i;
    chk("stall", bus.stall_o, st);
    chk("dec_ready", bus.dec_ready_o, exp_accept);
    if (!st) begin
      chk("fwd_a", bus.fwd_a_o, (ia < 0) ? 0 : q[ia].age);
      chk("fwd_data_a", bus.fwd_data_a_o, (ia < 0) ? 32'h0 : fdata(ia));
      chk("fwd_b", bus.fwd_b_o, (ib < 0) ? 0 : q[ib].age);
      chk("fwd_data_b", bus.fwd_data_b_o, (ib < 0) ? 32'h0 : fdata(ib));
    end
    w = -1;
    foreach (q[i]) if (q[i].age == 3 && q[i].we && q[i].rd != 5'd0) w = i;
    chk("RegWEn", bus.RegWEn_o, (w >= 0) ? 1 : 0);
    if (w >= 0) begin
      chk("AddrD", bus.AddrD_o, q[w].rd);
      chk("DataD", bus.DataD_o, q[w].data);
    end
  endtask

  // Clock edge: capture stage data, age everything, admit the accepted one.
  task automatic advance();
    @(posedge clk);
    foreach (q[i]) begin
      if (q[i].age == 1) q[i].data = bus.ex_result_i;
      else if (q[i].age == 2 && q[i].ld) q[i].data = bus.mem_rdata_i;
      q[i].age++;
    end
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].age > 3) q.delete(i);
    if (exp_accept)
      q.push_back('{rd: bus.dec_rd_i, we: bus.dec_we_i, ld: bus.dec_load_i, data: 32'h0, age: 1});
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic idle(input int n);
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; errors = 0; exp_accept = 1'b0;
    clk = 0; rst = 1;
    set_dec(0, 0, 0, 0, 3, 1, 3, 1, 0);
    bus.ex_result_i = 32'h0; bus.mem_rdata_i = 32'h0;
    #2;
    chk("rst_RegWEn", bus.RegWEn_o, 0);
    chk("rst_AddrD", bus.AddrD_o, 0);
    chk("rst_DataD", bus.DataD_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_fwd_a", bus.fwd_a_o, 0);
    chk("rst_fwd_b", bus.fwd_b_o, 0);
    @(posedge clk); #1;
    rst = 0;

    // Back-to-back write of x5 and forwarding from each stage.
    set_dec(1, 5, 1, 0, 0, 0, 0, 0, 0); step();
    set_dec(0, 0, 0, 0, 5, 1, 0, 0, 0); bus.ex_result_i = 32'h11;
    settle(); chk("fwd_ex_sel", bus.fwd_a_o, 1); chk("fwd_ex_data", bus.fwd_data_a_o, 32'h11); advance();
    bus.ex_result_i = 32'h99;
    settle(); chk("fwd_mem_sel", bus.fwd_a_o, 2); chk("fwd_mem_data", bus.fwd_data_a_o, 32'h11); advance();
    settle();
    if (BYPASS) chk("fwd_wb_sel", bus.fwd_a_o, 3);
    else chk("wb_stall", bus.stall_o, 1);
    chk("b2b_RegWEn", bus.RegWEn_o, 1); chk("b2b_AddrD", bus.AddrD_o, 5); chk("b2b_DataD", bus.DataD_o, 32'h11);
    advance();
    idle(3);

    // Load-use on x7 through source B.
    set_dec(1, 7, 1, 1, 0, 0, 0, 0, 0); step();
    set_dec(1, 9, 1, 0, 0, 0, 7, 1, 0);
    settle(); chk("lu_stall", bus.stall_o, 1); chk("lu_ready", bus.dec_ready_o, 0); advance();
    bus.mem_rdata_i = 32'hCAFE0000;
    settle(); chk("lu_stall_end", bus.stall_o, 0); chk("lu_fwd_b", bus.fwd_b_o, 2);
    chk("lu_fwd_data_b", bus.fwd_data_b_o, 32'hCAFE0000); advance();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0); bus.mem_rdata_i = 32'h12345678;
    settle(); chk("lu_AddrD", bus.AddrD_o, 7); chk("lu_DataD", bus.DataD_o, 32'hCAFE0000); advance();
    idle(3);

    // x0 is never forwarded, stalled on or written.
    set_dec(1, 0, 1, 1, 0, 0, 0, 0, 0); step();
    set_dec(0, 0, 0, 0, 0, 1, 0, 1, 0);
    settle(); chk("x0_fwd_a", bus.fwd_a_o, 0); chk("x0_stall", bus.stall_o, 0); advance();
    step();
    settle(); chk("x0_no_write", bus.RegWEn_o, 0); advance();

    // Flushed instruction is dropped.
    set_dec(1, 4, 1, 0, 0, 0, 0, 0, 1);
    settle(); chk("flush_ready", bus.dec_ready_o, 0); advance();
    idle(2);
    settle(); chk("flush_no_write", bus.RegWEn_o, 0); advance();

    // Random traffic with dense register reuse.
    for (int n = 0; n < 400; n++) begin
      set_dec($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 9) < 7,
              5'($urandom_range(0, 7)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      bus.ex_result_i = $urandom; bus.mem_rdata_i = $urandom;
      step();
    end

    // Reset with three instructions in flight.
    idle(3);
    for (int k = 1; k <= 3; k++) begin
      set_dec(1, 5'(k), 1, 0, 0, 0, 0, 0, 0); bus.ex_result_i = 32'h100 + k; step();
    end
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1; #1;
    chk("midrst_RegWEn", bus.RegWEn_o, 0);
    chk("midrst_stall", bus.stall_o, 0);
    @(posedge clk); #1;
    rst = 0; q.delete();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
